// File: rtl/uart_tx_sched.sv
// uart_tx_sched: pops 32-bit words from the CSR-fed FIFO and sends each one as four UART frames, least-significant byte first.
// Define UART_TX_PARITY_EN to add an even parity bit to each frame (8E1). The default build sends plain 8N1 frames.
module uart_tx_sched #(
   parameter int unsigned BaudDiv      = 174,
   parameter int unsigned BytesPerWord = 4
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        have_next,
   input  logic [31:0] data,
   output logic        next,
   output logic        tx,
   output logic        busy
);

   localparam logic [15:0] BaudLast    = 16'(BaudDiv - 1);
   localparam logic [1:0]  ByteLast    = 2'(BytesPerWord - 1);
   localparam logic [1:0]  HoldoffInit = 2'd2;

   if (BaudDiv < 4 || BaudDiv > 65535) begin : g_bad_baud
      $error("uart_tx_sched: BaudDiv must be in 4..65535");
   end
   if (BytesPerWord != 4) begin : g_bad_bytes
      $error("uart_tx_sched: BytesPerWord is fixed at 4");
   end

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } state_t;

   state_t      state, state_d;
   logic [15:0] baud_cnt, baud_d;
   logic [2:0]  bit_cnt, bit_d;
   logic [1:0]  byte_idx, byte_d;
   logic [31:0] shift_reg, shift_d;
   logic [1:0]  holdoff, holdoff_d;
   logic        tx_d;
   logic        bit_done;
   logic [7:0]  cur_byte;

   assign bit_done = (baud_cnt == BaudLast);

   // NOTE: every variable driven here gets a default at the top, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state;
      baud_d    = baud_cnt;
      bit_d     = bit_cnt;
      byte_d    = byte_idx;
      shift_d   = shift_reg;
      holdoff_d = holdoff;
      next      = 1'b0;

      if (state != ST_IDLE) begin
         baud_d = bit_done ? 16'd0 : baud_cnt + 16'd1;
      end

      case (state)
         ST_IDLE: begin
            // The FIFO flag is registered and may still read 1 just after a pop.
            if (holdoff != 2'd0) begin
               holdoff_d = holdoff - 2'd1;
            end else if (have_next && !reset_i) begin
               next    = 1'b1;
               shift_d = data;
               byte_d  = 2'd0;
               bit_d   = 3'd0;
               baud_d  = 16'd0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bit_done) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (bit_done) begin
               bit_d = bit_cnt + 3'd1;
`ifdef UART_TX_PARITY_EN
               if (bit_cnt == 3'd7) state_d = ST_PARITY;
`else
               if (bit_cnt == 3'd7) state_d = ST_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_done) state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (bit_done) begin
               if (byte_idx != ByteLast) begin
                  byte_d  = byte_idx + 2'd1;
                  shift_d = {8'h00, shift_reg[31:8]};
                  state_d = ST_START;
               end else begin
                  holdoff_d = HoldoffInit;
                  state_d   = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The line level is decoded from the next state, so tx can sit in a flop and still change on the bit boundary.
   assign cur_byte = shift_d[7:0];

   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = cur_byte[bit_d];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_d = ^cur_byte;
`endif
         default:   tx_d = 1'b1;
      endcase
   end

   // NOTE: state registers use non-blocking assignments only, so every flop samples the pre-edge values.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state     <= ST_IDLE;
         baud_cnt  <= 16'd0;
         bit_cnt   <= 3'd0;
         byte_idx  <= 2'd0;
         shift_reg <= 32'd0;
         holdoff   <= 2'd0;
         tx        <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state     <= state_d;
         baud_cnt  <= baud_d;
         bit_cnt   <= bit_d;
         byte_idx  <= byte_d;
         shift_reg <= shift_d;
         holdoff   <= holdoff_d;
         tx        <= tx_d;
         busy      <= (state_d != ST_IDLE);
      end
   end

   a_next_only_idle: assert property (@(posedge clk_i) disable iff (reset_i) next |-> !busy);
   a_next_one_cycle: assert property (@(posedge clk_i) disable iff (reset_i) next |=> !next);
   a_idle_line_high: assert property (@(posedge clk_i) disable iff (reset_i) !busy |-> tx);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a FIFO model feeds a table of words, and a UART receiver checks each byte against a scoreboard.
// It also exercises reset, holdoff against a stale flag, back-to-back spacing and a mid-frame reset.
module tb_uart_tx_sched;
   localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int WORD_CYC = 4 * FRAME_BITS * BD;
   localparam int HALF     = BD / 2;
   localparam int NVEC     = 9;

   logic        clk_i     = 1'b0;
   logic        reset_i   = 1'b1;
   logic        have_next = 1'b0;
   logic [31:0] data      = 32'hDEAD_BEEF;
   logic        next;
   logic        tx;
   logic        busy;

   uart_tx_sched #(.BaudDiv(BD), .BytesPerWord(4)) dut (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .have_next (have_next),
      .data      (data),
      .next      (next),
      .tx        (tx),
      .busy      (busy)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] word;
      logic [7:0]  exp_bytes [4];
   } vec_t;

   vec_t        vecs [NVEC];
   logic [31:0] fifo_q [$];
   logic [7:0]  pend_bytes [$];
   logic [7:0]  sb_q [$];
   int          exp_start_q [$];
   int          pop_cyc [$];
   int          busy_runs [$];

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   pop_count = 0;
   int   busy_run = 0;
   int   rx_phase = -1;
   int   prev_start = 0;
   int   frame_idx = 0;
   int   slot;
   logic [7:0] rx_byte = 8'h00;
   logic flag_d1 = 1'b0;
   logic stale_force = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
      #1;
   endtask

   task automatic push_vec(input vec_t v);
      fifo_q.push_back(v.word);
      for (int i = 0; i < 4; i++) pend_bytes.push_back(v.exp_bytes[i]);
   endtask

   task automatic wait_done(input string name, input int target, input int budget);
      int  n = 0;
      logic done = 1'b0;
      while (!done && n < budget) begin
         tick();
         n++;
         done = (pop_count >= target) && !busy && (sb_q.size() == 0);
      end
      check(name, 32'(done), 32'd1);
   endtask

   // FIFO model: the non-empty flag reaches have_next two registered stages late.
   always @(posedge clk_i) begin
      #1;
      have_next = stale_force | flag_d1;
      flag_d1   = (fifo_q.size() != 0);
      data      = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
   end

   always @(negedge clk_i) begin
      cyc++;
      if (!reset_i && next) begin
         pop_count++;
         pop_cyc.push_back(cyc);
         exp_start_q.push_back(cyc + 1);
         check("pop_has_word", 32'(fifo_q.size() != 0), 32'd1);
         if (fifo_q.size() != 0) void'(fifo_q.pop_front());
         for (int i = 0; i < 4; i++) if (pend_bytes.size() != 0) sb_q.push_back(pend_bytes.pop_front());
      end

      if (reset_i) busy_run = 0;
      else if (busy) busy_run++;
      else if (busy_run != 0) begin
         busy_runs.push_back(busy_run);
         busy_run = 0;
      end

      if (reset_i) begin
         rx_phase  = -1;
         frame_idx = 0;
      end else if (rx_phase < 0) begin
         if (tx == 1'b0) begin
            rx_phase = 0;
            if (frame_idx == 0) begin
               if (exp_start_q.size() != 0) check("start_latency", cyc, exp_start_q.pop_front());
               else check("frame_without_pop", 32'd0, 32'd1);
            end else begin
               check("frame_spacing", cyc - prev_start, FRAME_BITS * BD);
            end
            prev_start = cyc;
         end
      end else begin
         rx_phase++;
      end

      if (!reset_i && rx_phase >= 0 && (rx_phase % BD) == HALF) begin
         slot = rx_phase / BD;
         if (slot == 0) begin
            check("start_bit", 32'(tx), 32'd0);
         end else if (slot <= 8) begin
            rx_byte = {tx, rx_byte[7:1]};
         end else if (slot == FRAME_BITS - 1) begin
            check("stop_bit", 32'(tx), 32'd1);
            if (sb_q.size() != 0) check("rx_byte", 32'(rx_byte), 32'(sb_q.pop_front()));
            else check("unexpected_frame", 32'(rx_byte), 32'hFFFF_FFFF);
            rx_phase  = -1;
            frame_idx = (frame_idx + 1) % 4;
         end else begin
            if (sb_q.size() != 0) check("parity_bit", 32'(tx), 32'(^sb_q[0]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int p;
      int n;

      vecs[0] = '{32'h5544_3322, '{8'h22, 8'h33, 8'h44, 8'h55}};
      vecs[1] = '{32'h0000_00FF, '{8'hFF, 8'h00, 8'h00, 8'h00}};
      vecs[2] = '{32'h0000_0001, '{8'h01, 8'h00, 8'h00, 8'h00}};
      vecs[3] = '{32'h0000_0007, '{8'h07, 8'h00, 8'h00, 8'h00}};
      vecs[4] = '{32'hA5C3_0F81, '{8'h81, 8'h0F, 8'hC3, 8'hA5}};
      vecs[5] = '{32'hFFFF_FFFF, '{8'hFF, 8'hFF, 8'hFF, 8'hFF}};
      vecs[6] = '{32'h8001_7E18, '{8'h18, 8'h7E, 8'h01, 8'h80}};
      vecs[7] = '{32'h1234_5678, '{8'h78, 8'h56, 8'h34, 8'h12}};
      vecs[8] = '{32'h9ABC_DEF0, '{8'hF0, 8'hDE, 8'hBC, 8'h9A}};

      // Reset held with a word already waiting in the FIFO.
      reset_i = 1'b1;
      push_vec(vecs[0]);
      repeat (2) tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_tx", 32'(tx), 32'd1);
         check("rst_next", 32'(next), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
      end
      @(posedge clk_i);
      #1 reset_i = 1'b0;
      tick();
      check("first_next_after_release", 32'(next), 32'd1);
      check("pop_count_first", pop_count, 32'd1);

      // Stale flag: have_next stays 1 through the word and the two cycles after it returns to IDLE.
      stale_force = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (busy && n < WORD_CYC + 20);
      check("word0_ends", 32'(busy), 32'd0);
      tick();
      stale_force = 1'b0;
      repeat (10) tick();
      check("holdoff_no_pop", pop_count, 32'd1);
      check("sb_drained_word0", sb_q.size(), 32'd0);
      if (busy_runs.size() != 0) check("busy_len_word0", busy_runs.pop_front(), WORD_CYC);
      else check("busy_len_word0_missing", 32'd0, 32'd1);

      // Back-to-back batch of table words.
      base = pop_count;
      for (int i = 1; i <= 6; i++) push_vec(vecs[i]);
      wait_done("batch_done", base + 6, 6 * (WORD_CYC + 3) + 60);
      check("batch_pops", pop_count, base + 6);
      for (int k = base; k < base + 5 && k + 1 < pop_cyc.size(); k++) begin
         check("pop_gap", pop_cyc[k + 1] - pop_cyc[k], WORD_CYC + 3);
      end
      for (int i = 0; i < 6; i++) begin
         if (busy_runs.size() != 0) check("busy_len_batch", busy_runs.pop_front(), WORD_CYC);
         else check("busy_len_batch_missing", 32'd0, 32'd1);
      end

      // Mid-frame reset during bit 3 of byte 1; the following word must start fresh from byte 0.
      base = pop_count;
      push_vec(vecs[7]);
      push_vec(vecs[8]);
      n = 0;
      while (pop_count == base && n < 20) begin
         tick();
         n++;
      end
      check("midrst_pop", pop_count, base + 1);
      p = pop_cyc[pop_cyc.size() - 1];
      n = 0;
      while (cyc < p + 58 && n < 100) begin
         tick();
         n++;
      end
      check("midrst_pre_tx", 32'(tx), 32'd0);
      #1 reset_i = 1'b1;
      #1;
      check("midrst_tx_async", 32'(tx), 32'd1);
      check("midrst_busy_async", 32'(busy), 32'd0);
      sb_q.delete();
      exp_start_q.delete();
      repeat (2) begin
         tick();
         check("midrst_next_held", 32'(next), 32'd0);
      end
      @(posedge clk_i);
      #1 reset_i = 1'b0;
      tick();
      check("midrst_next_after_release", 32'(next), 32'd1);
      wait_done("midrst_done", base + 2, WORD_CYC + 40);
      check("midrst_pops", pop_count, base + 2);
      if (busy_runs.size() != 0) check("busy_len_after_rst", busy_runs.pop_front(), WORD_CYC);
      else check("busy_len_after_rst_missing", 32'd0, 32'd1);

      repeat (5) tick();
      check("fifo_empty", fifo_q.size(), 32'd0);
      check("sb_empty", sb_q.size(), 32'd0);
      check("idle_tx", 32'(tx), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
